// File: rtl/alu_issue_ctrl.sv
// Generic FIFO with a registered head: head_dat only changes on a pop or on a push into an empty FIFO.
// Latency: a push is visible at head_dat after one edge. There is no overflow guard; callers push only when count < DEPTH.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_vld,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop_vld,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic          empty;
  logic          last;

  assign rd_ptr_nxt = rd_ptr + 1'b1;
  assign empty      = (count == '0);
  assign last       = (count == (AW+1)'(1));

  always_ff @(posedge clk) begin
    if (push_vld)
      mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head_dat <= '0;
    end else begin
      if (push_vld)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_vld)
        rd_ptr <= rd_ptr_nxt;
      case ({push_vld, pop_vld})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // Head reloads from the incoming word when it is (or becomes) the only entry.
      if (push_vld && (empty || (pop_vld && last)))
        head_dat <= push_dat;
      else if (pop_vld && !empty && !last)
        head_dat <= mem[rd_ptr_nxt];
    end
  end
endmodule

// Issue stage for a one-cycle registered ALU: request FIFO -> operand regs -> tag shadow -> result FIFO.
// Latency: accept at E, issue E+1, ALU capture E+2, result written E+3. Issue stalls while results queued + in flight reach 4.
module alu_issue_ctrl #(
  parameter int N     = 16,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [2:0]       alu_op,
  input  logic [N-1:0]     alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);
  localparam int AW        = $clog2(DEPTH);
  localparam int RES_DEPTH = 4;

  typedef struct packed {
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [N-1:0]     result;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } res_t;

  req_t        req_in_dat;
  req_t        req_head_dat;
  logic        req_push_vld;
  logic        req_pop_vld;
  logic [AW:0] req_count;
  logic        req_full;
  logic        req_empty;

  res_t        res_in_dat;
  res_t        res_head_dat;
  logic        res_pop_vld;
  logic [2:0]  res_count;

  logic             iss_v;
  logic             iss_ill;
  logic [TAG_W-1:0] iss_tag;
  logic             alu_v;
  logic             alu_ill;
  logic [TAG_W-1:0] alu_tag;
  logic [3:0]       credit_sum;

  assign req_full     = (req_count == (AW+1)'(DEPTH));
  assign req_empty    = (req_count == '0);
  assign in_ready     = rst_n && !req_full;
  assign req_push_vld = in_valid && in_ready;
  assign req_in_dat   = {in_a, in_b, in_op, in_tag};

  sync_fifo #(
    .W     ($bits(req_t)),
    .DEPTH (DEPTH)
  ) u_req (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (req_push_vld),
    .push_dat (req_in_dat),
    .pop_vld  (req_pop_vld),
    .head_dat (req_head_dat),
    .count    (req_count)
  );

  // Every op already issued or inside the ALU will land in the result FIFO, so reserve its slot now.
  assign credit_sum  = 4'(res_count) + 4'(iss_v) + 4'(alu_v);
  assign req_pop_vld = !req_empty && (credit_sum < 4'(RES_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= 3'd7;
      iss_v   <= 1'b0;
      iss_tag <= '0;
      iss_ill <= 1'b0;
      alu_v   <= 1'b0;
      alu_tag <= '0;
      alu_ill <= 1'b0;
    end else begin
      iss_v <= req_pop_vld;
      if (req_pop_vld) begin
        alu_a   <= req_head_dat.a;
        alu_b   <= req_head_dat.b;
        alu_op  <= req_head_dat.op;
        iss_tag <= req_head_dat.tag;
        iss_ill <= (req_head_dat.op[2:1] == 2'b11);
      end
      // Shadow of the ALU result register: alu_result belongs to alu_tag when alu_v is set.
      alu_v   <= iss_v;
      alu_tag <= iss_tag;
      alu_ill <= iss_ill;
    end
  end

  assign res_in_dat  = {alu_result, alu_tag, alu_ill};
  assign out_valid   = (res_count != '0);
  assign res_pop_vld = out_valid && out_ready;

  sync_fifo #(
    .W     ($bits(res_t)),
    .DEPTH (RES_DEPTH)
  ) u_res (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (alu_v),
    .push_dat (res_in_dat),
    .pop_vld  (res_pop_vld),
    .head_dat (res_head_dat),
    .count    (res_count)
  );

  assign out_result  = res_head_dat.result;
  assign out_tag     = res_head_dat.tag;
  assign out_illegal = res_head_dat.ill;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: models the registered ALU, scores results against an arithmetic reference.
module tb_alu_issue_ctrl;
  localparam int N     = 16;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     in_a = '0;
  logic [N-1:0]     in_b = '0;
  logic [2:0]       in_op = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [N-1:0]     alu_a;
  logic [N-1:0]     alu_b;
  logic [2:0]       alu_op;
  logic [N-1:0]     alu_result = 16'hDEAD;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N-1:0]     out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int n_acc = 0;

  typedef struct {
    logic [N-1:0]     result;
    logic [TAG_W-1:0] tag;
    logic             ill;
    int               cyc;
  } res_s;

  res_s exp_q[$];
  res_s got_q[$];

  alu_issue_ctrl #(.N(N), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_op       (in_op),
    .in_tag      (in_tag),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // Registered ALU stage; it has no reset, so it keeps stale data across a DUT reset.
  always @(posedge clk) begin
    case (alu_op)
      3'd0:    alu_result <= alu_a + alu_b;
      3'd1:    alu_result <= alu_a - alu_b;
      3'd2:    alu_result <= alu_a & alu_b;
      3'd3:    alu_result <= alu_a | alu_b;
      3'd4:    alu_result <= alu_a ^ alu_b;
      3'd5:    alu_result <= alu_a << 1;
      default: alu_result <= '0;
    endcase
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(dut.alu_v && dut.res_count == 3'd4))
        else begin
          miscompares++;
          $error("FAIL result_overflow: write into full result fifo at cycle %0d", cycle);
        end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [N-1:0] ref_alu(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [2:0] op);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd0:    r = (ia + ib) % 65536;
      3'd1:    r = (ia - ib + 65536) % 65536;
      3'd2:    r = int'(a & b);
      3'd3:    r = int'(a | b);
      3'd4:    r = int'(a ^ b);
      3'd5:    r = (ia * 2) % 65536;
      default: r = 0;
    endcase
    return r[N-1:0];
  endfunction

  // Advance one clock from a negedge, logging accepted requests and delivered results.
  task automatic tick();
    #1;
    if (in_valid && in_ready) begin
      exp_q.push_back('{ref_alu(in_a, in_b, in_op), in_tag, (in_op >= 3'd6), 0});
      n_acc++;
    end
    if (out_valid && out_ready)
      got_q.push_back('{out_result, out_tag, out_illegal, cycle});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 60 && got_q.size() < exp_q.size(); k++)
      tick();
  endtask

  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
    n_acc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (alu_op !== 3'd7) begin miscompares++; $display("FAIL reset_alu_op got %0d want 7", alu_op); end
    vectors++; if ({alu_a, alu_b} !== 32'h0) begin miscompares++; $display("FAIL reset_alu_ab got %h want 0", {alu_a, alu_b}); end
    vectors++; if ({out_result, out_tag, out_illegal} !== 21'h0) begin
      miscompares++; $display("FAIL reset_out_regs got %h want 0", {out_result, out_tag, out_illegal});
    end
    rst_n = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_single();
    clear_queues();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 16'h00FF; in_b = 16'h0001; in_op = 3'd0; in_tag = 4'd3;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_valid cycle+%0d got %b want 0", k, out_valid); end
      tick();
    end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b want 1", out_valid); end
    vectors++; if (out_result !== 16'h0100) begin miscompares++; $display("FAIL single_result got %h want 0100", out_result); end
    vectors++; if (out_tag !== 4'd3) begin miscompares++; $display("FAIL single_tag got %0d want 3", out_tag); end
    vectors++; if (out_illegal !== 1'b0) begin miscompares++; $display("FAIL single_illegal got %b want 0", out_illegal); end
    drain();
    vectors++; if (got_q.size() !== 1) begin miscompares++; $display("FAIL single_count got %0d want 1", got_q.size()); end
  endtask

  task automatic test_stream();
    clear_queues();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_a = N'($urandom); in_b = N'($urandom);
      in_op = 3'($urandom_range(5)); in_tag = TAG_W'(i);
      for (int k = 0; k < 10 && n_acc == i; k++)
        tick();
    end
    drain();
    vectors++; if (got_q.size() !== 8) begin miscompares++; $display("FAIL stream_count got %0d want 8", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i].result !== exp_q[i].result || got_q[i].tag !== TAG_W'(i) || got_q[i].ill !== 1'b0) begin
        miscompares++;
        $display("FAIL stream_item%0d got %h/%0d/%b want %h/%0d/0", i, got_q[i].result, got_q[i].tag,
                 got_q[i].ill, exp_q[i].result, i);
      end
      vectors++;
      if (got_q[i].cyc !== got_q[0].cyc + i) begin
        miscompares++; $display("FAIL stream_rate item%0d at cycle %0d want %0d", i, got_q[i].cyc, got_q[0].cyc + i);
      end
    end
  endtask

  task automatic test_illegal();
    clear_queues();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF; in_op = 3'(6 + i); in_tag = TAG_W'(9 + i);
      for (int k = 0; k < 10 && n_acc == i; k++)
        tick();
    end
    drain();
    vectors++; if (got_q.size() !== 2) begin miscompares++; $display("FAIL illegal_count got %0d want 2", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i].result !== 16'h0 || got_q[i].ill !== 1'b1 || got_q[i].tag !== TAG_W'(9 + i)) begin
        miscompares++;
        $display("FAIL illegal_item%0d got %h/%b/%0d want 0000/1/%0d", i, got_q[i].result, got_q[i].ill, got_q[i].tag, 9 + i);
      end
    end
  endtask

  // Leaves the DUT with both FIFOs full and op 8 still offered.
  task automatic test_backpressure();
    logic [N-1:0] head;
    clear_queues();
    out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (n_acc < 10) begin
        in_valid = 1'b1;
        in_a = N'($urandom); in_b = N'($urandom);
        in_op = 3'($urandom_range(7)); in_tag = TAG_W'(n_acc);
      end
      if (c == 12) head = out_result;
      tick();
    end
    vectors++; if (n_acc !== 8) begin miscompares++; $display("FAIL bp_accepted got %0d want 8", n_acc); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    vectors++; if (dut.res_count !== 3'd4) begin miscompares++; $display("FAIL bp_buffered got %0d want 4", dut.res_count); end
    vectors++; if (got_q.size() !== 0) begin miscompares++; $display("FAIL bp_leak got %0d want 0", got_q.size()); end
    vectors++; if (out_result !== exp_q[0].result || head !== exp_q[0].result) begin
      miscompares++; $display("FAIL bp_head_stable got %h then %h want %h", head, out_result, exp_q[0].result);
    end
  endtask

  task automatic test_full_pushpop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL pushpop_in_ready got %b want 0", in_ready); end
    tick();
    vectors++; if (n_acc !== 8) begin miscompares++; $display("FAIL pushpop_no_push got %0d want 8", n_acc); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL pushpop_after_pop got %b want 1", in_ready); end
    drain();
    vectors++; if (got_q.size() !== 8) begin miscompares++; $display("FAIL bp_delivered got %0d want 8", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i].result !== exp_q[i].result || got_q[i].tag !== TAG_W'(i) || got_q[i].ill !== exp_q[i].ill) begin
        miscompares++;
        $display("FAIL bp_item%0d got %h/%0d/%b want %h/%0d/%b", i, got_q[i].result, got_q[i].tag, got_q[i].ill,
                 exp_q[i].result, i, exp_q[i].ill);
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [N-1:0] a, b;
    clear_queues();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_a = N'($urandom); in_b = N'($urandom); in_op = 3'd4; in_tag = TAG_W'(i);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++; if (alu_op !== 3'd7) begin miscompares++; $display("FAIL midop_async got %0d want 7", alu_op); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_queues();
    for (int k = 0; k < 6; k++) begin
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midop_stale_valid cycle %0d got %b want 0", k, out_valid); end
      tick();
    end
    a = N'($urandom); b = N'($urandom);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = 3'd1; in_tag = 4'd5;
    for (int k = 0; k < 10 && n_acc == 0; k++)
      tick();
    drain();
    vectors++; if (got_q.size() !== 1) begin miscompares++; $display("FAIL midop_count got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      vectors++;
      if (got_q[0].result !== ref_alu(a, b, 3'd1) || got_q[0].tag !== 4'd5) begin
        miscompares++;
        $display("FAIL midop_result got %h/%0d want %h/5", got_q[0].result, got_q[0].tag, ref_alu(a, b, 3'd1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_illegal();
    test_backpressure();
    test_full_pushpop();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
